// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase scheduler for a two-road intersection with a pedestrian crossing.
// Optional build macro EMERGENCY_PREEMPT_EN adds the 'emerg' preemption input.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 5,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg,
`endif
  input  logic       car_a,
  input  logic       car_b,
  input  logic       ped_req,
  output logic [2:0] light_A,
  output logic [2:0] light_B,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [2:0] ST_ALL_RED  = 3'd0;
  localparam logic [2:0] ST_A_GREEN  = 3'd1;
  localparam logic [2:0] ST_A_YELLOW = 3'd2;
  localparam logic [2:0] ST_B_GREEN  = 3'd3;
  localparam logic [2:0] ST_B_YELLOW = 3'd4;
  localparam logic [2:0] ST_PED_WALK = 3'd5;

  localparam logic [1:0] SRV_A   = 2'd0;
  localparam logic [1:0] SRV_B   = 2'd1;
  localparam logic [1:0] SRV_PED = 2'd2;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT   = '1;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] timer;
  logic             timer_clear;
  logic             ped_pend;
  logic [1:0]       last_served;
  logic [2:0]       grant_state;
  logic [1:0]       grant_srv;
  logic             emerg_on;
  logic             ped_entry;

`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_on = emerg;
`else
  assign emerg_on = 1'b0;
`endif

  // Round-robin pick starting after the last served phase; rest on A when idle.
  always_comb begin
    grant_state = ST_A_GREEN;
    grant_srv   = SRV_A;
    case (last_served)
      SRV_A: begin
        if (car_b) begin
          grant_state = ST_B_GREEN;  grant_srv = SRV_B;
        end else if (ped_pend) begin
          grant_state = ST_PED_WALK; grant_srv = SRV_PED;
        end
      end
      SRV_B: begin
        if (ped_pend) begin
          grant_state = ST_PED_WALK; grant_srv = SRV_PED;
        end else if (car_a) begin
          grant_state = ST_A_GREEN;  grant_srv = SRV_A;
        end else if (car_b) begin
          grant_state = ST_B_GREEN;  grant_srv = SRV_B;
        end
      end
      default: begin
        if (car_a) begin
          grant_state = ST_A_GREEN;  grant_srv = SRV_A;
        end else if (car_b) begin
          grant_state = ST_B_GREEN;  grant_srv = SRV_B;
        end else if (ped_pend) begin
          grant_state = ST_PED_WALK; grant_srv = SRV_PED;
        end
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ALL_RED:
        if (!emerg_on && timer >= ALLRED_LAST) state_next = grant_state;
      ST_A_GREEN:
        if (emerg_on || ((car_b || ped_pend) && timer >= GMIN_LAST &&
                         (!car_a || timer >= GMAX_LAST)))
          state_next = ST_A_YELLOW;
      ST_B_GREEN:
        if (emerg_on || ((car_a || ped_pend) && timer >= GMIN_LAST &&
                         (!car_b || timer >= GMAX_LAST)))
          state_next = ST_B_YELLOW;
      ST_A_YELLOW, ST_B_YELLOW:
        if (timer >= YELLOW_LAST) state_next = ST_ALL_RED;
      ST_PED_WALK:
        if (emerg_on || timer >= WALK_LAST) state_next = ST_ALL_RED;
      default:
        state_next = ST_ALL_RED;
    endcase
  end

  // Holding in ALL_RED under preemption pins the timer so clearance restarts afterwards.
  assign timer_clear = (state_next != state) || (state == ST_ALL_RED && emerg_on);
  assign ped_entry   = (state_next == ST_PED_WALK) && (state != ST_PED_WALK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_ALL_RED;
      timer       <= '0;
      ped_pend    <= 1'b0;
      last_served <= SRV_PED;
    end else begin
      state <= state_next;
      if (timer_clear)
        timer <= '0;
      else if (timer != TIMER_SAT)
        timer <= timer + 1'b1;
      if (ped_entry)
        ped_pend <= 1'b0;
      else if (ped_req)
        ped_pend <= 1'b1;
      if (state == ST_ALL_RED && state_next != ST_ALL_RED)
        last_served <= grant_srv;
    end
  end

  always_comb begin
    light_A = LAMP_RED;
    light_B = LAMP_RED;
    case (state)
      ST_A_GREEN:  light_A = LAMP_GREEN;
      ST_A_YELLOW: light_A = LAMP_YELLOW;
      ST_B_GREEN:  light_B = LAMP_GREEN;
      ST_B_YELLOW: light_B = LAMP_YELLOW;
      default: ;
    endcase
  end

  assign walk    = (state == ST_PED_WALK);
  assign ped_ack = (state == ST_PED_WALK) && (timer == '0);
  assign phase   = state;

endmodule
